framebuffer_arbiter: RTL and testbench
======================================

# framebuffer_arbiter

Shares the single VGA adapter pixel-write port (x, y, colour, plot) between the sprite drawers: ship, asteroid generator, bullets and score. Round-robin arbitration with bounded bursts; at each frame boundary it sequences a full-screen clear before drawers are served again. Sits between the drawers and the VGA adapter inside the graphics path of the top-level game module.

## Interface
Parameters:
- N_REQ, 4, number of requesting drawers (2..8)
- MAX_BURST, 16, max pixels accepted per grant before forced rotation (1..255)
- CLEAR_COLOUR, 3'b000, colour written during frame clear

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse requesting a screen clear
- req  in  N_REQ  per-drawer request, held high for the whole burst
- req_plot  in  N_REQ  per-drawer pixel valid
- req_x  in  8*N_REQ  packed x, drawer i at [8i+7:8i]
- req_y  in  7*N_REQ  packed y, drawer i at [7i+6:7i]
- req_colour  in  3*N_REQ  packed colour, drawer i at [3i+2:3i]
- grant  out  N_REQ  one-hot grant (all-zero when none)
- vga_x  out  8  pixel x to adapter
- vga_y  out  7  pixel y to adapter
- vga_colour  out  3  pixel colour to adapter
- vga_plot  out  1  write enable to adapter
- clearing  out  1  high while in CLEAR
- clear_done  out  1  one-cycle pulse with final clear pixel

## Operation
- States: IDLE, CLEAR, GRANT.
- IDLE: frame_start or clear_pending -> CLEAR (priority over req). Else if any req: pick first requester after last_grant (cyclic, ascending index), load grant, burst_cnt=0 -> GRANT.
- GRANT: pixel accepted when req_plot[g] && grant[g]; accepted pixel's x/y/colour registered to vga_* with vga_plot=1. Exit to IDLE (grant cleared next cycle) when req[g]=0, or when accepted pixel brings burst_cnt to MAX_BURST. last_grant updates to g on exit.
- req_plot from non-granted drawers ignored; no pixel lost for granted drawer as long as it only drives req_plot while grant is seen high.
- CLEAR: x counter 0..159 inner, y 0..119 outer; one pixel per cycle, colour CLEAR_COLOUR. After (159,119) -> IDLE, clear_pending cleared.
- frame_start during GRANT: set clear_pending; honoured at next IDLE, ahead of requests. frame_start during CLEAR: ignored (no restart, no pending).
- Coordinates passed unmodified; arbiter does not clip.
- Reset: state IDLE, grant 0, vga_x/vga_y/vga_colour/vga_plot 0, clearing 0, clear_done 0, last_grant = N_REQ-1 (drawer 0 wins first), clear_pending 0, counters 0.

## Timing
- req rising in IDLE -> grant high next cycle (1-cycle arbitration).
- Accepted pixel in cycle t -> vga_* valid, vga_plot high in t+1; vga_plot 0 in any cycle without accepted/clear pixel.
- Burst end: grant low the cycle after final accepted pixel or after req seen low; min one IDLE cycle between grants.
- frame_start sampled in IDLE at t -> clearing high t+1, first clear pixel (0,0) on vga_* at t+2; 19200 consecutive plot cycles; clear_done with (159,119); clearing low the cycle after.
- Max wait for a requester: (N_REQ-1)*(MAX_BURST+1) cycles, plus 19200+2 if a clear intervenes.

## Structure
- Shared package asteroids_pkg: SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3, arbiter state enum.
- Sub-module rr_pick: combinational round-robin picker (req, last_grant -> one-hot next, any). Rest (FSM, counters, output registers) in framebuffer_arbiter.

## Test plan
- Reset, req=4'b0011 both plotting continuously -> grant 0001 for 16 pixels, 1 idle cycle, 0010 for 16, then 0001.
- Drawer 2 requests, drops req after 3 pixels (5,7),(6,7),(7,7) colour 3'b100 -> exactly those three on vga_* one cycle later, grant low next cycle.
- frame_start in IDLE -> 19200 plot cycles, first (0,0), last (159,119) with clear_done, all colour 000.
- frame_start mid-burst of drawer 1 -> burst completes, CLEAR runs before pending drawer 3 is granted.
- req_plot from ungranted drawer 3 while drawer 0 granted -> no drawer-3 pixel appears.
- reset asserted mid-CLEAR at pixel (40,10) -> next cycle all outputs 0, IDLE; new frame_start restarts at (0,0).

Source files
------------

// File: rtl/asteroids_pkg.sv
// Shared definitions for the asteroids graphics path.
// Holds the screen geometry, pixel field widths, the framebuffer arbiter
// state encoding and a helper that recognises the last pixel of a clear.
package asteroids_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  // Arbiter states, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  // True on the bottom-right pixel, i.e. the final pixel of a screen clear.
  function automatic logic clear_last(input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y);
    return (x == X_W'(SCREEN_W - 1)) && (y == Y_W'(SCREEN_H - 1));
  endfunction

endpackage

// File: rtl/framebuffer_arbiter_rr_pick.sv
// Combinational round-robin picker for the framebuffer arbiter.
// Ports:
//   req        in  per-drawer request vector
//   last_grant in  index of the drawer served most recently
//   next_oh    out one-hot winner (first requester after last_grant, ascending, wrapping)
//   next_idx   out index of the winner
//   any        out at least one requester present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] next_oh,
  output logic [IDX_W-1:0] next_idx,
  output logic             any
);

  int cand_s;

  // Scan from last_grant+1 around to last_grant itself; first hit wins.
  always_comb begin
    next_oh  = '0;
    next_idx = '0;
    any      = 1'b0;
    cand_s   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = (int'(last_grant) + k) % N_REQ;
      if (!any && req[cand_s[IDX_W-1:0]]) begin
        next_oh[cand_s[IDX_W-1:0]] = 1'b1;
        next_idx                   = cand_s[IDX_W-1:0];
        any                        = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares the VGA adapter pixel-write port between sprite drawers.
// Round-robin grants with bursts bounded to MAX_BURST accepted pixels, and a
// full-screen clear sequenced at each frame boundary ahead of any drawer.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   frame_start            single-cycle pulse requesting a screen clear
//   req/req_plot           per-drawer request (held for burst) and pixel valid
//   req_x/req_y/req_colour packed per-drawer pixel fields
//   grant                  one-hot grant, all-zero when none
//   vga_x/vga_y/vga_colour/vga_plot  registered pixel write to the adapter
//   clearing               high while the clear sequence runs
//   clear_done             one-cycle pulse alongside the final clear pixel
module framebuffer_arbiter
  import asteroids_pkg::*;
#(
  parameter int                    N_REQ        = 4,
  parameter int                    MAX_BURST    = 16,
  parameter logic [COLOUR_W-1:0]   CLEAR_COLOUR = 3'b000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_plot,
  input  logic [X_W*N_REQ-1:0]      req_x,
  input  logic [Y_W*N_REQ-1:0]      req_y,
  input  logic [COLOUR_W*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]          grant,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_plot,
  output logic                      clearing,
  output logic                      clear_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]          state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic                clear_pending_q, clear_pending_d;
  logic [X_W-1:0]      x_cnt_q, x_cnt_d;
  logic [Y_W-1:0]      y_cnt_q, y_cnt_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;
  logic                clearing_q, clearing_d;
  logic                clear_done_q, clear_done_d;

  logic [N_REQ-1:0]    pick_oh_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic                accept_s;
  logic [X_W-1:0]      sel_x_s;
  logic [Y_W-1:0]      sel_y_s;
  logic [COLOUR_W-1:0] sel_colour_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .next_oh    (pick_oh_s),
    .next_idx   (pick_idx_s),
    .any        (pick_any_s)
  );

  // Select the granted drawer's pixel fields and decide whether it is accepted.
  always_comb begin
    sel_x_s      = req_x[int'(gidx_q)*X_W +: X_W];
    sel_y_s      = req_y[int'(gidx_q)*Y_W +: Y_W];
    sel_colour_s = req_colour[int'(gidx_q)*COLOUR_W +: COLOUR_W];
    accept_s     = req_plot[gidx_q] & grant_q[gidx_q];
  end

  // Next-state logic for the arbiter FSM, counters and output registers.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    gidx_d          = gidx_q;
    last_grant_d    = last_grant_q;
    burst_cnt_d     = burst_cnt_q;
    clear_pending_d = clear_pending_q;
    x_cnt_d         = x_cnt_q;
    y_cnt_d         = y_cnt_q;
    vga_x_d         = vga_x_q;
    vga_y_d         = vga_y_q;
    vga_colour_d    = vga_colour_q;
    vga_plot_d      = 1'b0;
    clearing_d      = clearing_q;
    clear_done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A clear always wins over drawers, whether fresh or deferred.
        if (frame_start || clear_pending_q) begin
          state_d    = ST_CLEAR;
          x_cnt_d    = '0;
          y_cnt_d    = '0;
          clearing_d = 1'b1;
        end else if (pick_any_s) begin
          state_d     = ST_GRANT;
          grant_d     = pick_oh_s;
          gidx_d      = pick_idx_s;
          burst_cnt_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        vga_x_d      = x_cnt_q;
        vga_y_d      = y_cnt_q;
        vga_colour_d = CLEAR_COLOUR;
        vga_plot_d   = 1'b1;
        if (clear_last(x_cnt_q, y_cnt_q)) begin
          state_d         = ST_IDLE;
          clearing_d      = 1'b0;
          clear_done_d    = 1'b1;
          clear_pending_d = 1'b0;
          x_cnt_d         = '0;
          y_cnt_d         = '0;
        end else if (x_cnt_q == X_W'(SCREEN_W - 1)) begin
          x_cnt_d = '0;
          y_cnt_d = y_cnt_q + 7'd1;
        end else begin
          x_cnt_d = x_cnt_q + 8'd1;
        end
      end
      ST_GRANT: begin
        // A frame boundary mid-burst is remembered, not acted on yet.
        if (frame_start) begin
          clear_pending_d = 1'b1;
        end else begin
          clear_pending_d = clear_pending_q;
        end
        if (accept_s) begin
          vga_x_d      = sel_x_s;
          vga_y_d      = sel_y_s;
          vga_colour_d = sel_colour_s;
          vga_plot_d   = 1'b1;
          burst_cnt_d  = burst_cnt_q + 8'd1;
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
        if (!req[gidx_q] || (accept_s && ((burst_cnt_q + 8'd1) == 8'(MAX_BURST)))) begin
          state_d      = ST_IDLE;
          grant_d      = '0;
          last_grant_d = gidx_q;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        clearing_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      gidx_q          <= '0;
      last_grant_q    <= IDX_W'(N_REQ - 1);
      burst_cnt_q     <= 8'd0;
      clear_pending_q <= 1'b0;
      x_cnt_q         <= '0;
      y_cnt_q         <= '0;
      vga_x_q         <= '0;
      vga_y_q         <= '0;
      vga_colour_q    <= '0;
      vga_plot_q      <= 1'b0;
      clearing_q      <= 1'b0;
      clear_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      gidx_q          <= gidx_d;
      last_grant_q    <= last_grant_d;
      burst_cnt_q     <= burst_cnt_d;
      clear_pending_q <= clear_pending_d;
      x_cnt_q         <= x_cnt_d;
      y_cnt_q         <= y_cnt_d;
      vga_x_q         <= vga_x_d;
      vga_y_q         <= vga_y_d;
      vga_colour_q    <= vga_colour_d;
      vga_plot_q      <= vga_plot_d;
      clearing_q      <= clearing_d;
      clear_done_q    <= clear_done_d;
    end
  end

  assign grant      = grant_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign clearing   = clearing_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Self-checking bench for framebuffer_arbiter (default parameters).
// Drawer models plot only while they see their grant; every pixel expected on
// the VGA port is queued in order and popped by a negedge monitor.
module tb_framebuffer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [3:0]  req, req_plot;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  grant;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, clearing, clear_done;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       done;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt[4];
  int   lim[4];
  bit   rogue3;

  framebuffer_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .req        (req),
    .req_plot   (req_plot),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .grant      (grant),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .clearing   (clearing),
    .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pixel k of drawer i: distinct per drawer so misrouted pixels are visible.
  function automatic pix_t drawer_pix(input int i, input int k);
    pix_t p;
    case (i)
      2:       begin p.x = 8'(5 + k);      p.y = 7'd7;      p.c = 3'b100; end
      3:       begin p.x = 8'(200 + k);    p.y = 7'd50;     p.c = 3'b110; end
      default: begin p.x = 8'(40 * i + k); p.y = 7'(i + 1); p.c = 3'(i + 1); end
    endcase
    p.done = 1'b0;
    return p;
  endfunction

  task automatic push_drawer(input int i, input int from, input int n);
    for (int k = from; k < from + n; k++) exp_q.push_back(drawer_pix(i, k));
  endtask

  task automatic push_clear(input int n);
    pix_t p;
    for (int j = 0; j < n; j++) begin
      p.x    = 8'(j % 160);
      p.y    = 7'(j / 160);
      p.c    = 3'b000;
      p.done = (j == 19199);
      exp_q.push_back(p);
    end
  endtask

  // One clock; afterwards each drawer reacts to the grant it now sees.
  task automatic step();
    pix_t p;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && cnt[i] >= lim[i]) begin
        req[i] = 1'b0;
        req_plot[i] = 1'b0;
      end else if (req[i] && grant[i]) begin
        p = drawer_pix(i, cnt[i]);
        req_x[8*i +: 8]      = p.x;
        req_y[7*i +: 7]      = p.y;
        req_colour[3*i +: 3] = p.c;
        req_plot[i] = 1'b1;
        cnt[i]++;
      end else begin
        req_plot[i] = 1'b0;
      end
    end
    if (rogue3) begin
      p = drawer_pix(3, 99);
      req_x[31:24]     = p.x;
      req_y[27:21]     = p.y;
      req_colour[11:9] = p.c;
      req_plot[3]      = 1'b1;
    end
  endtask

  task automatic reset_drawers();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      lim[i] = 0;
    end
  endtask

  // Scoreboard monitor: every plotted pixel must be the next expected one.
  always @(negedge clk) begin
    pix_t e;
    if (vga_plot) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_plot", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("pixel", {vga_x, vga_y, vga_colour, clear_done}, e);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; frame_start = 1'b0; rogue3 = 1'b0;
    req = '0; req_plot = '0; req_x = '0; req_y = '0; req_colour = '0;
    reset_drawers();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", {grant, vga_x, vga_y, vga_colour, vga_plot, clearing, clear_done}, 0);
    reset = 1'b0;

    // Two drawers plotting continuously: 16-pixel bursts alternating with one idle cycle.
    lim[0] = 17; lim[1] = 16;
    push_drawer(0, 0, 16); push_drawer(1, 0, 16); push_drawer(0, 16, 1);
    req = 4'b0011;
    for (int k = 1; k <= 35; k++) begin
      step();
      check_eq("t1_grant", grant,
               (k <= 16) ? 4'b0001 : (k == 17) ? 4'b0000 :
               (k <= 33) ? 4'b0010 : (k == 34) ? 4'b0000 : 4'b0001);
    end
    repeat (4) step();
    check_eq("t1_drained", exp_q.size(), 0);
    check_eq("t1_grant_end", grant, 4'b0000);

    // Drawer 2 drops req after three pixels.
    reset_drawers(); lim[2] = 3; push_drawer(2, 0, 3);
    req = 4'b0100;
    step(); check_eq("t2_grant", grant, 4'b0100);
    step(); step(); step();
    check_eq("t2_grant_held", grant, 4'b0100);
    step(); check_eq("t2_release", grant, 4'b0000);
    repeat (3) step();
    check_eq("t2_drained", exp_q.size(), 0);

    // Ungranted drawer 3 asserts req_plot while drawer 0 owns the port.
    reset_drawers(); lim[0] = 4; push_drawer(0, 0, 4);
    rogue3 = 1'b1;
    req = 4'b0001;
    step(); check_eq("t5_grant", grant, 4'b0001);
    repeat (5) step();
    rogue3 = 1'b0; req_plot[3] = 1'b0;
    repeat (3) step();
    check_eq("t5_drained", exp_q.size(), 0);

    // Full-screen clear from IDLE.
    push_clear(19200);
    frame_start = 1'b1;
    step(); frame_start = 1'b0;
    check_eq("t3_clearing", clearing, 1'b1);
    n = 0;
    while (!clear_done && n < 19300) begin step(); n++; end
    check_eq("t3_done_latency", n, 19200);
    step(); check_eq("t3_clear_low", clearing, 1'b0);
    check_eq("t3_drained", exp_q.size(), 0);

    // frame_start mid-burst of drawer 1: burst finishes, clear, then drawer 3.
    reset_drawers(); lim[1] = 6; lim[3] = 4;
    push_drawer(1, 0, 6); push_clear(19200); push_drawer(3, 0, 4);
    req = 4'b1010;
    step(); check_eq("t4_grant1", grant, 4'b0010);
    step(); step();
    frame_start = 1'b1;
    step(); frame_start = 1'b0;
    check_eq("t4_grant1_held", grant, 4'b0010);
    n = 0;
    while (!clearing && n < 50) begin step(); n++; end
    check_eq("t4_clear_seen", clearing, 1'b1);
    check_eq("t4_no_grant_in_clear", grant, 4'b0000);
    n = 0;
    while (clearing && n < 19300) begin step(); n++; end
    n = 0;
    while (grant == 4'b0000 && n < 10) begin step(); n++; end
    check_eq("t4_grant3", grant, 4'b1000);
    repeat (8) step();
    check_eq("t4_drained", exp_q.size(), 0);

    // Reset mid-clear at pixel (40,10), then a fresh clear from (0,0).
    reset_drawers(); req = '0;
    push_clear(1640);
    frame_start = 1'b1;
    step(); frame_start = 1'b0;
    repeat (1640) step();
    reset = 1'b1;
    step();
    check_eq("t6_reset_outs", {grant, vga_x, vga_y, vga_colour, vga_plot, clearing, clear_done}, 0);
    reset = 1'b0;
    check_eq("t6_partial_drained", exp_q.size(), 0);
    push_clear(19200);
    frame_start = 1'b1;
    step(); frame_start = 1'b0;
    check_eq("t6_clearing", clearing, 1'b1);
    n = 0;
    while (!clear_done && n < 19300) begin step(); n++; end
    check_eq("t6_done_latency", n, 19200);
    repeat (3) step();
    check_eq("t6_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
